adder_arbiter: RTL and testbench

//   Shares one WIDTH-bit integer adder between NREQ requesters, e.g. PC+4,

---
 rtl/adder_arbiter.sv | 93 +++++++++
 tb/tb_adder_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters.
// Result is registered one deep and tagged with the winning requester id.
module adder_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry
);

    logic [IDW-1:0]   rr_ptr;
    logic             can_acc;
    logic             found;
    logic [IDW-1:0]   gid;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum_w;

    // Rotate so the scan always starts at bit 0, then map back to an index.
    function automatic logic [IDW:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [IDW-1:0]  ptr
    );
        logic [2*NREQ-1:0] dbl;
        logic [IDW:0]      r;
        logic [IDW:0]      t;
        dbl = {v, v} >> ptr;
        r   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                t = {1'b0, ptr} + (IDW+1)'(k);
                if (t >= (IDW+1)'(NREQ)) begin
                    t = t - (IDW+1)'(NREQ);
                end
                r = {1'b1, t[IDW-1:0]};
            end
        end
        return r;
    endfunction

    assign can_acc = !rsp_valid || rsp_ready;

    always_comb begin
        found = 1'b0;
        gid   = '0;
        if (can_acc) begin
            {found, gid} = rr_pick(req_valid, rr_ptr);
        end
    end

    assign req_ready = found ? (NREQ'(1) << gid) : '0;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gid == IDW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_w = {1'b0, a_sel} + {1'b0, b_sel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rr_ptr    <= '0;
        end else if (found) begin
            {rsp_carry, rsp_sum} <= sum_w;
            rsp_id    <= gid;
            rsp_valid <= 1'b1;
            rr_ptr    <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter.
// Inputs change at posedge+1; outputs are sampled a few ns later.
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    int checks;
    int errors;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", rsp_valid);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_sum !== 32'd0 || rsp_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got id=%0d sum=%h c=%b want 0/0/0",
                     rsp_id, rsp_sum, rsp_carry);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        set_op(0, 32'd5, 32'd7);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL basic_ready got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd12
            || rsp_carry !== 1'b0) begin
            errors++;
            $display("FAIL basic_rsp got v=%b id=%0d sum=%0d c=%b want 1/0/12/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
    endtask

    task automatic test_carry();
        set_op(1, 32'hFFFF_FFFF, 32'd1);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL carry_ready got %b want 0010", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'd0
            || rsp_carry !== 1'b1) begin
            errors++;
            $display("FAIL carry_wrap got v=%b id=%0d sum=%h c=%b want 1/1/0/1",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        set_op(2, 32'h7FFF_FFFF, 32'd1);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h8000_0000
            || rsp_carry !== 1'b0) begin
            errors++;
            $display("FAIL carry_signed got v=%b id=%0d sum=%h c=%b want 1/2/80000000/0",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_sum [4];
        logic [IDW-1:0]   g;
        exp_sum = '{32'd101, 32'd202, 32'd303, 32'd404};
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, WIDTH'(100 * (i + 1)), WIDTH'(i + 1));
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            g = IDW'(k % 4);
            #1;
            checks++;
            if (req_ready !== (4'b0001 << g)) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b want %b",
                         k, req_ready, 4'b0001 << g);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== g || rsp_sum !== exp_sum[g]) begin
                errors++;
                $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%0d want 1/%0d/%0d",
                         k, rsp_valid, rsp_id, rsp_sum, g, exp_sum[g]);
            end
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_ready got %b want 0000", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1
                || rsp_sum !== 32'd202) begin
                errors++;
                $display("FAIL stall_hold[%0d] got rdy=%b v=%b id=%0d sum=%0d want 0000/1/1/202",
                         k, req_ready, rsp_valid, rsp_id, rsp_sum);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL unstall_ready got %b want 0100", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'd303) begin
            errors++;
            $display("FAIL unstall_rsp got v=%b id=%0d sum=%0d want 1/2/303",
                     rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_async_reset();
        step();
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL areset_clear got v=%b id=%0d sum=%0d want 0/0/0",
                     rsp_valid, rsp_id, rsp_sum);
        end
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_ready got %b want 0001", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'd101) begin
            errors++;
            $display("FAIL areset_first got v=%b id=%0d sum=%0d want 1/0/101",
                     rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_req2_after_3();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL last_ready got %b want 1000", req_ready);
        end
        step();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL only2_ready got %b want 0100", req_ready);
        end
        step();
        checks++;
        if (rsp_id !== 2'd2 || rsp_sum !== 32'd303 || dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL only2_rsp got id=%0d sum=%0d ptr=%0d want 2/303/3",
                     rsp_id, rsp_sum, dut.rr_ptr);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ptr3_ready got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 32'd404) begin
            errors++;
            $display("FAIL ptr3_rsp got v=%b id=%0d sum=%0d want 1/3/404",
                     rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_stall();
        test_async_reset();
        test_req2_after_3();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
